// File: rtl/pulse_avg_sched.sv
// pulse_avg_sched -- frame scheduler in front of the pulse CIR averager.
// Gates the wrapper stream into the averager in frames of avg_size packets,
// applies new configuration only at frame boundaries (with a soft core reset),
// waits for the averaged result to leave before opening the next frame, and
// keeps status counters for readback.
//
// Optional feature: define PULSE_AVG_SCHED_STATS_EN to implement drop_cnt,
// len_err_cnt and timeout_cnt; otherwise those outputs read as 0.
//
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   enable                      run request (level)
//   cfg_stb, cfg_*              config capture strobe and values
//   s_tdata/s_tlast/s_tvalid/s_tready   input stream from wrapper
//   m_tdata/m_tlast/m_tvalid/m_tready   stream to averager
//   mon_tlast/mon_tvalid/mon_tready     taps on averager output handshake
//   core_rst_n                  soft reset to averager (active low)
//   act_*                       active config to averager
//   state, pkt_cnt              FSM state, packets in current frame
//   drop_cnt/len_err_cnt/timeout_cnt    saturating status counters
module pulse_avg_sched #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        enable,
  input  logic        cfg_stb,
  input  logic [15:0] cfg_seq_len,
  input  logic [31:0] cfg_avg_size,
  input  logic [31:0] cfg_threshold,
  input  logic [31:0] s_tdata,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  input  logic        mon_tlast,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  output logic        core_rst_n,
  output logic [15:0] act_seq_len,
  output logic [31:0] act_avg_size,
  output logic [31:0] act_threshold,
  output logic [1:0]  state,
  output logic [31:0] pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] len_err_cnt,
  output logic [15:0] timeout_cnt
);

  localparam int unsigned LW  = 16;
  localparam int unsigned BW  = LW + 1;  // one extra bit so overlong packets never alias seq_len
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TW  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             alive_q, alive_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_seq_len_q, pend_seq_len_d;
  logic [31:0]      pend_avg_size_q, pend_avg_size_d;
  logic [31:0]      pend_threshold_q, pend_threshold_d;
  logic [15:0]      act_seq_len_q, act_seq_len_d;
  logic [31:0]      act_avg_size_q, act_avg_size_d;
  logic [31:0]      act_threshold_q, act_threshold_d;

  logic        run_hs, tlast_hs, at_boundary, frame_done, mon_done;
  logic        wait_expired, rst_first, rst_last;
  logic [31:0] pkt_inc, eff_avg;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign run_hs       = (state_q == ST_RUN) && s_tvalid && m_tready;
  assign tlast_hs     = run_hs && s_tlast;
  assign pkt_inc      = (pkt_cnt_q == 32'hFFFF_FFFF) ? pkt_cnt_q : pkt_cnt_q + 32'd1;
  assign eff_avg      = (act_avg_size_q == 32'd0) ? 32'd1 : act_avg_size_q;
  // A beat-0 cycle only counts as a boundary if no first beat is being taken.
  assign at_boundary  = tlast_hs || ((beat_q == '0) && !run_hs);
  assign frame_done   = (tlast_hs ? pkt_inc : pkt_cnt_q) >= eff_avg;
  // An empty frame produces no averaged result, so there is nothing to wait for.
  assign mon_done     = (mon_tvalid && mon_tready && mon_tlast) || (pkt_cnt_q == 32'd0);
  assign wait_expired = (wait_q == TW'(DRAIN_TIMEOUT - 1));
  assign rst_first    = (state_q == ST_RESET) && (rst_cnt_q == '0);
  assign rst_last     = (rst_cnt_q == RCW'(RST_CYCLES - 1));

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RESET;
      ST_RESET: if (rst_last) state_d = ST_RUN;
      ST_RUN:   if (at_boundary && (frame_done || !enable || pend_q)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (mon_done) begin
          if (!enable)     state_d = ST_IDLE;
          else if (pend_q) state_d = ST_RESET;
          else             state_d = ST_RUN;
        end else if (wait_expired) begin
          state_d = enable ? ST_RESET : ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: RUN is a zero-latency pass-through; alive_q keeps s_tready
  // and core_rst_n low until the first clock after reset release.
  always_comb begin
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tdata    = '0;
    core_rst_n = alive_q;
    case (state_q)
      ST_IDLE:  s_tready = alive_q;
      ST_RESET: core_rst_n = 1'b0;
      ST_RUN: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tlast  = s_tlast;
        m_tdata  = s_tdata;
      end
      default: ;
    endcase
  end

  // Datapath next-state: counters, pending and active configuration
  always_comb begin
    alive_d          = 1'b1;
    rst_cnt_d        = '0;
    beat_d           = '0;
    wait_d           = '0;
    pkt_cnt_d        = pkt_cnt_q;
    pend_d           = pend_q;
    pend_seq_len_d   = pend_seq_len_q;
    pend_avg_size_d  = pend_avg_size_q;
    pend_threshold_d = pend_threshold_q;
    act_seq_len_d    = act_seq_len_q;
    act_avg_size_d   = act_avg_size_q;
    act_threshold_d  = act_threshold_q;

    if (state_q == ST_RESET && !rst_last) rst_cnt_d = rst_cnt_q + RCW'(1);
    if (state_q == ST_DRAIN)              wait_d    = wait_q + TW'(1);

    if (state_q == ST_RUN) begin
      beat_d = beat_q;
      if (run_hs) begin
        if (s_tlast)                beat_d = '0;
        else if (beat_q != '1)      beat_d = beat_q + BW'(1);
      end
    end

    if (rst_first)                                       pkt_cnt_d = '0;
    else if (tlast_hs)                                   pkt_cnt_d = pkt_inc;
    else if (state_q == ST_DRAIN && state_d == ST_RUN)   pkt_cnt_d = '0;

    // A strobe in the first RESET cycle bypasses the pending slot.
    if (rst_first) begin
      if (cfg_stb) begin
        act_seq_len_d   = cfg_seq_len;
        act_avg_size_d  = cfg_avg_size;
        act_threshold_d = cfg_threshold;
      end else if (pend_q) begin
        act_seq_len_d   = pend_seq_len_q;
        act_avg_size_d  = pend_avg_size_q;
        act_threshold_d = pend_threshold_q;
      end
      pend_d = 1'b0;
    end else if (cfg_stb) begin
      pend_d           = 1'b1;
      pend_seq_len_d   = cfg_seq_len;
      pend_avg_size_d  = cfg_avg_size;
      pend_threshold_d = cfg_threshold;
    end
  end

  // Datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      alive_q          <= 1'b0;
      rst_cnt_q        <= '0;
      beat_q           <= '0;
      wait_q           <= '0;
      pkt_cnt_q        <= '0;
      pend_q           <= 1'b0;
      pend_seq_len_q   <= '0;
      pend_avg_size_q  <= '0;
      pend_threshold_q <= '0;
      act_seq_len_q    <= '0;
      act_avg_size_q   <= 32'd1;
      act_threshold_q  <= '0;
    end else begin
      alive_q          <= alive_d;
      rst_cnt_q        <= rst_cnt_d;
      beat_q           <= beat_d;
      wait_q           <= wait_d;
      pkt_cnt_q        <= pkt_cnt_d;
      pend_q           <= pend_d;
      pend_seq_len_q   <= pend_seq_len_d;
      pend_avg_size_q  <= pend_avg_size_d;
      pend_threshold_q <= pend_threshold_d;
      act_seq_len_q    <= act_seq_len_d;
      act_avg_size_q   <= act_avg_size_d;
      act_threshold_q  <= act_threshold_d;
    end
  end

  assign state         = state_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign act_seq_len   = act_seq_len_q;
  assign act_avg_size  = act_avg_size_q;
  assign act_threshold = act_threshold_q;

`ifdef PULSE_AVG_SCHED_STATS_EN
  logic [15:0] drop_q, drop_d, len_err_q, len_err_d, timeout_q, timeout_d;
  logic        len_bad;

  assign len_bad = (beat_q + BW'(1)) != {1'b0, act_seq_len_q};

  // Status counters
  always_comb begin
    drop_d    = drop_q;
    len_err_d = len_err_q;
    timeout_d = timeout_q;
    if (state_q == ST_IDLE && alive_q && s_tvalid && s_tlast) drop_d = sat_inc16(drop_q);
    if (tlast_hs && len_bad)                                  len_err_d = sat_inc16(len_err_q);
    if (state_q == ST_DRAIN && !mon_done && wait_expired)     timeout_d = sat_inc16(timeout_q);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_q    <= '0;
      len_err_q <= '0;
      timeout_q <= '0;
    end else begin
      drop_q    <= drop_d;
      len_err_q <= len_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign drop_cnt    = drop_q;
  assign len_err_cnt = len_err_q;
  assign timeout_cnt = timeout_q;
`else
  assign drop_cnt    = '0;
  assign len_err_cnt = '0;
  assign timeout_cnt = '0;
`endif

endmodule

// File: doc/pulse_avg_sched.md
# pulse_avg_sched

Frame scheduler for the pulse CIR averaging core. Sits between the AXI wrapper's `m_axis_data` stream and the HLS averager. It does four things:
- gates input packets into the averager in frames of `avg_size` packets;
- holds configuration stable during a frame and applies new settings only at frame boundaries, with a soft reset of the core;
- waits for the averaged result to leave before starting the next frame;
- reports state and error counters for readback.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `core_rst_n` is held low in RESET (≥1).
- `DRAIN_TIMEOUT`, 65535: max DRAIN cycles before forced recovery.

Ports:
- `ap_clk`  in  1  single clock; all logic on rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request (level).
- `cfg_stb`  in  1  one-cycle strobe: capture `cfg_*` as pending config.
- `cfg_seq_len`  in  16  packet length in beats.
- `cfg_avg_size`  in  32  packets per frame; 0 treated as 1.
- `cfg_threshold`  in  32  sample threshold.
- `s_tdata`/`s_tlast`/`s_tvalid`  in  32/1/1  input stream from wrapper.
- `s_tready`  out  1  input ready.
- `m_tdata`/`m_tlast`/`m_tvalid`  out  32/1/1  stream to averager.
- `m_tready`  in  1  averager ready.
- `mon_tlast`/`mon_tvalid`/`mon_tready`  in  1 each  taps on averager output handshake.
- `core_rst_n`  out  1  soft reset to averager, active low.
- `act_seq_len`/`act_avg_size`/`act_threshold`  out  16/32/32  active config to averager.
- `state`  out  2  IDLE=0, RESET=1, RUN=2, DRAIN=3.
- `pkt_cnt`  out  32  packets accepted in current frame.
- `drop_cnt`/`len_err_cnt`/`timeout_cnt`  out  16 each  saturating status counters.

## Operation
- IDLE:
  - `s_tready`=1; input is discarded; `drop_cnt`++ per tlast handshake.
  - `m_tvalid`=0.
  - `enable`=1 → RESET.
- RESET:
  - `core_rst_n`=0 for `RST_CYCLES`; `s_tready`=0.
  - First cycle: active ← pending config if pending flag is set, and pending flag clears. If `cfg_stb` is high in that same cycle, active ← `cfg_*` directly and pending clears.
  - `pkt_cnt`←0. Then → RUN.
- RUN:
  - Combinational pass-through: `m_*`=`s_*`, `s_tready`=`m_tready`.
  - A beat counter counts handshakes. On a tlast handshake: `pkt_cnt`++; if beats ≠ `act_seq_len`, `len_err_cnt`++; beat counter clears.
  - At a packet boundary only (beat counter=0, or the current cycle is a tlast handshake) → DRAIN when any of these holds: `pkt_cnt` reaches max(`act_avg_size`,1); `enable`=0; pending config set.
  - Never leave RUN mid-packet.
- DRAIN:
  - `s_tready`=0, `m_tvalid`=0; wait-cycle counter runs.
  - On `mon_tvalid&mon_tready&mon_tlast`: → IDLE if `enable`=0; else → RESET if pending config is set; else → RUN with `pkt_cnt`←0.
  - If the wait counter reaches `DRAIN_TIMEOUT`: `timeout_cnt`++, → RESET (or IDLE if `enable`=0).
  - Entering DRAIN with 0 packets in the frame skips the wait.
- `cfg_stb` in any other state: overwrite pending, set the pending flag. The latest strobe wins.
- `act_*` change only in RESET.

## Timing
- RUN data path: 0-cycle latency, no registers; `m_tvalid` must not depend on `m_tready`.
- State transitions are registered: 1 cycle after the triggering handshake.
- `core_rst_n` low for exactly `RST_CYCLES` consecutive cycles per RESET entry.
- Async reset values:
  - `state`=IDLE; `core_rst_n`=0; `s_tready`=0 during reset, 1 once in IDLE.
  - `m_tvalid`=0; all counters=0.
  - `act_seq_len`=0, `act_avg_size`=1, `act_threshold`=0; pending flag clear.
- Reset asserted mid-packet or mid-frame: immediate abort to the reset values; no partial state is kept.
- Counters saturate at all-ones, no wrap. `pkt_cnt` is 32-bit and is compared against `act_avg_size` with unsigned compare.

## Configuration
- `PULSE_AVG_SCHED_STATS_EN` defined: `drop_cnt`, `len_err_cnt` and `timeout_cnt` are implemented as specified.
- Not defined:
  - those three outputs are tied to 0 and their counter logic is removed;
  - IDLE still discards input and the DRAIN timeout still forces recovery;
  - `pkt_cnt` and `state` are always present.

## Test plan
- Basic frame: `cfg_seq_len`=8, `cfg_avg_size`=4, `enable`=1; send 4×8-beat packets, then a `mon` tlast. Required: `core_rst_n` low 4 cycles; 32 beats pass unchanged; DRAIN after packet 4; RUN resumes with `pkt_cnt`=0.
- Config mid-packet: `cfg_stb` with `avg_size`=2 at beat 3 of packet 1. Required: packet 1 completes; DRAIN; after the `mon` tlast, RESET; `act_avg_size`=2.
- Length error: packet of 7 beats with `seq_len`=8. Required: `len_err_cnt`=1; `pkt_cnt` still increments.
- Disabled input: `enable`=0, send 3 packets. Required: all accepted, `m_tvalid` never 1, `drop_cnt`=3.
- Drain timeout: `DRAIN_TIMEOUT`=16, no `mon` tlast. Required: `timeout_cnt`=1 after 16 DRAIN cycles, then RESET.
- Async reset mid-packet: drop `ap_rst_n` at beat 4. Required: immediate IDLE, counters 0, `m_tvalid`=0, `core_rst_n`=0.
